contador_modulo_n: RTL and testbench

CONTADOR_MODULO_N -- requirements
Module: contador_modulo_n

---
 rtl/contador_pkg.sv | 11 +
 rtl/sincronizador_borda.sv | 37 +++
 rtl/contador_modulo_n.sv | 102 ++++++++++
 tb/tb_contador_modulo_n.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared constants for the modulo-N counter: count direction encodings and default geometry.
package contador_pkg;

  localparam logic CONTA_CIMA  = 1'b1;
  localparam logic CONTA_BAIXO = 1'b0;

  localparam int unsigned WIDTH_PADRAO  = 3;
  localparam int unsigned MODULO_PADRAO = 6;
  localparam int unsigned PRESET_PADRAO = 5;

endpackage

// File: rtl/sincronizador_borda.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge detector.
module sincronizador_borda (
  input  logic clk,
  input  logic reset_n,
  input  logic sinal_i,
  output logic borda_o
);

  logic sinc1_q, sinc2_q, ant_q;
  logic vld_q;
  logic armado_q, armado_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sinc1_q  <= 1'b0;
      sinc2_q  <= 1'b0;
      ant_q    <= 1'b0;
      vld_q    <= 1'b0;
      armado_q <= 1'b0;
    end else begin
      sinc1_q  <= sinal_i;
      sinc2_q  <= sinc1_q;
      ant_q    <= sinc2_q;
      vld_q    <= 1'b1;
      armado_q <= armado_d;
    end
  end

  // Edges are only honoured once a genuine low has been sampled after reset, so an input
  // already high at release is seen as a level, not a rising edge.
  always_comb begin
    armado_d = armado_q | (vld_q & ~sinc1_q);
  end

  assign borda_o = sinc2_q & ~ant_q & armado_q;

endmodule

// File: rtl/contador_modulo_n.sv
// Up/down modulo-N counter with enable, synchronised sensor preset load and terminal-count pulse.
module contador_modulo_n
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_PADRAO,
  parameter int unsigned MODULO = MODULO_PADRAO,
  parameter int unsigned PRESET = PRESET_PADRAO,
  parameter bit          WRAP   = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             on_off,
  input  logic             sensor_prox,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ativo
);

  if ((WIDTH < 2) || (WIDTH > 16)) begin : gen_bad_width
    $error("contador_modulo_n: WIDTH must be in 2..16");
  end
  if ((MODULO < 2) || (MODULO > (32'd1 << WIDTH))) begin : gen_bad_modulo
    $error("contador_modulo_n: MODULO must be in 2..2**WIDTH");
  end
  if (PRESET >= MODULO) begin : gen_bad_preset
    $error("contador_modulo_n: PRESET must be below MODULO");
  end

  // One extra bit so MODULO == 2**WIDTH still has a representable limit and no silent overflow.
  localparam int unsigned     W1    = WIDTH + 1;
  localparam logic [W1-1:0]   Limite = W1'(MODULO - 1);
  localparam logic [WIDTH-1:0] Carga = WIDTH'(PRESET);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ativo_q;
  logic             borda;
  logic [W1-1:0]    atual, prox;

  sincronizador_borda u_sinc_sensor (
    .clk     (clk),
    .reset_n (reset_n),
    .sinal_i (sensor_prox),
    .borda_o (borda)
  );

  assign atual = {1'b0, count_q};

  always_comb begin
    prox    = atual;
    count_d = count_q;
    tc_d    = 1'b0;
    if (!on_off) begin
      count_d = '0;
    end else if (borda) begin
      count_d = Carga;
    end else if (atual > Limite) begin
      count_d = '0;
    end else begin
      if (up_down == CONTA_CIMA) begin
        if (atual == Limite) begin
          if (WRAP) begin
            prox = '0;
            tc_d = 1'b1;
          end
        end else begin
          prox = atual + W1'(1);
          if (!WRAP && (prox == Limite)) tc_d = 1'b1;
        end
      end else begin
        if (atual == '0) begin
          if (WRAP) begin
            prox = Limite;
            tc_d = 1'b1;
          end
        end else begin
          prox = atual - W1'(1);
          if (!WRAP && (prox == '0)) tc_d = 1'b1;
        end
      end
      count_d = prox[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ativo_q <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ativo_q <= on_off;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ativo = ativo_q;

endmodule

// File: tb/tb_contador_modulo_n.sv
// Directed bench for contador_modulo_n: default, saturating and full-range (16) instances.
module tb_contador_modulo_n;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       on_off = 1'b0;
  logic       sensor_prox = 1'b0;
  logic       up_down = 1'b1;

  logic [2:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;
  logic       tc_a, tc_b, tc_c;
  logic       at_a, at_b, at_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  contador_modulo_n u_dut_a (
    .clk (clk), .reset_n (reset_n), .on_off (on_off), .sensor_prox (sensor_prox),
    .up_down (up_down), .count (cnt_a), .tc (tc_a), .ativo (at_a)
  );

  contador_modulo_n #(.WRAP (1'b0)) u_dut_b (
    .clk (clk), .reset_n (reset_n), .on_off (on_off), .sensor_prox (sensor_prox),
    .up_down (up_down), .count (cnt_b), .tc (tc_b), .ativo (at_b)
  );

  contador_modulo_n #(.WIDTH (4), .MODULO (16)) u_dut_c (
    .clk (clk), .reset_n (reset_n), .on_off (on_off), .sensor_prox (sensor_prox),
    .up_down (up_down), .count (cnt_c), .tc (tc_c), .ativo (at_c)
  );

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted and released 1 time unit after a rising edge.
  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  int unsigned seq_up[7] = '{1, 2, 3, 4, 5, 0, 1};
  int unsigned seq_tc[7] = '{0, 0, 0, 0, 0, 1, 0};
  int unsigned dn_cnt[6] = '{5, 4, 3, 4, 5, 0};
  int unsigned dn_tc[6]  = '{1, 0, 0, 0, 0, 1};
  int          tc_pulses;

  initial begin
    // Reset state
    #12;
    check_eq("reset_count", cnt_a, 0);
    check_eq("reset_tc", tc_a, 0);
    check_eq("reset_ativo", at_a, 0);
    tick();
    reset_n = 1'b1;

    // Default wrap-up sequence
    on_off  = 1'b1;
    up_down = 1'b1;
    do_reset();
    check_eq("up_start", cnt_a, 0);
    check_eq("ativo_pre", at_a, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq($sformatf("up_cnt%0d", i), cnt_a, seq_up[i]);
      check_eq($sformatf("up_tc%0d", i), tc_a, seq_tc[i]);
    end
    check_eq("ativo_on", at_a, 1);

    // Down from 0 with wrap, then direction change
    up_down = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) up_down = 1'b1;
      tick();
      check_eq($sformatf("dn_cnt%0d", i), cnt_a, dn_cnt[i]);
      check_eq($sformatf("dn_tc%0d", i), tc_a, dn_tc[i]);
      if (i == 0) begin
        check_eq("sat_low_cnt", cnt_b, 0);
        check_eq("sat_low_tc", tc_b, 0);
      end
    end

    // Saturating instance: up 10 cycles, then down 6
    up_down = 1'b1;
    do_reset();
    tc_pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_eq($sformatf("sat_up%0d", i), cnt_b, (i < 5) ? i : 5);
      check_eq($sformatf("sat_up_tc%0d", i), tc_b, (i == 5) ? 1 : 0);
      tc_pulses += int'(tc_b);
    end
    check_eq("sat_up_pulses", tc_pulses, 1);
    up_down = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_eq($sformatf("sat_dn%0d", i), cnt_b, (i < 5) ? 5 - i : 0);
      check_eq($sformatf("sat_dn_tc%0d", i), tc_b, (i == 5) ? 1 : 0);
    end

    // Sensor preset load: 3 edges after the rise
    up_down = 1'b1;
    do_reset();
    tick();
    tick();
    check_eq("pre_sensor", cnt_a, 2);
    sensor_prox = 1'b1;
    tick();
    check_eq("sens_e1", cnt_a, 3);
    tick();
    check_eq("sens_e2", cnt_a, 4);
    tick();
    check_eq("sens_load", cnt_a, 5);
    check_eq("sens_load_tc", tc_a, 0);
    tick();
    check_eq("sens_resume", cnt_a, 0);
    check_eq("sens_resume_tc", tc_a, 1);
    sensor_prox = 1'b0;

    // Disable mid-count, sensor pulse while off
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    check_eq("off_pre", cnt_a, 4);
    on_off = 1'b0;
    check_eq("off_ativo_pre", at_a, 1);
    tick();
    check_eq("off_cnt", cnt_a, 0);
    check_eq("off_ativo", at_a, 0);
    sensor_prox = 1'b1;
    tick();
    tick();
    sensor_prox = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("off_hold", cnt_a, 0);
    on_off = 1'b1;
    tick();
    check_eq("reen_cnt1", cnt_a, 1);
    check_eq("reen_ativo", at_a, 1);
    tick();
    check_eq("reen_cnt2", cnt_a, 2);

    // Full-range instance: reset at 9 with sensor high, then wrap 15->0
    do_reset();
    for (int i = 0; i < 9; i++) tick();
    check_eq("c_pre", cnt_c, 9);
    sensor_prox = 1'b1;
    reset_n = 1'b0;
    #1;
    check_eq("c_rst_cnt", cnt_c, 0);
    check_eq("c_rst_tc", tc_c, 0);
    check_eq("c_rst_ativo", at_c, 0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check_eq($sformatf("c_cnt%0d", i), cnt_c, i % 16);
      check_eq($sformatf("c_tc%0d", i), tc_c, (i == 16) ? 1 : 0);
    end
    sensor_prox = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
